// File: rtl/int_service_ctrl_if.sv
// Bus between the interrupt service controller and the pipeline.
//   int_src  : raw interrupt source levels (rising edge = request)
//   int_ack  : pipeline accepts the pending request
//   eret     : return-from-interrupt retiring this cycle
//   pc_in    : resume PC captured on an accepted ack
//   int_req  : request to pipeline
//   int_vec  : handler address of the requested source (0 when idle)
//   epc_out  : top of EPC stack (0 when empty)
//   ir / irs : pending / in-service registers
// master = pipeline/source side, slave = controller.
interface int_service_ctrl_if;
  logic [2:0]  int_src;
  logic        int_ack;
  logic        eret;
  logic [31:0] pc_in;
  logic        int_req;
  logic [31:0] int_vec;
  logic [31:0] epc_out;
  logic [2:0]  ir;
  logic [2:0]  irs;

  modport master (
    output int_src, int_ack, eret, pc_in,
    input  int_req, int_vec, epc_out, ir, irs
  );

  modport slave (
    input  int_src, int_ack, eret, pc_in,
    output int_req, int_vec, epc_out, ir, irs
  );
endinterface

// File: rtl/int_service_ctrl.sv
// Interrupt service controller. Latches rising edges of three sources into
// IR, tracks in-service levels in IRS, requests the pipeline with a handler
// vector, and keeps a 3-deep EPC stack of interrupted PCs. Source 2 has the
// highest priority; only strictly higher-priority sources preempt.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : int_service_ctrl_if.slave (see interface header)
module int_service_ctrl #(
  parameter logic [31:0] VEC0 = 32'h0000_0100,
  parameter logic [31:0] VEC1 = 32'h0000_0200,
  parameter logic [31:0] VEC2 = 32'h0000_0300
) (
  input  logic              clk,
  input  logic              rst,
  int_service_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [2:0]  src_q;
  logic [2:0]  ir_q;
  logic [2:0]  irs_q;
  logic [1:0]  sp;
  logic [1:0]  req_id;
  logic [31:0] epc [0:2];
  logic        int_req_q;
  logic [31:0] int_vec_q;

  logic [2:0]  rise;
  logic [2:0]  avail;
  logic        top_vld;
  logic [1:0]  top;
  logic        cand_vld;
  logic [1:0]  cand;
  logic        eligible;
  logic        eret_ok;
  logic        accept;
  logic [2:0]  ack_mask;
  logic [2:0]  irs_nxt;

  function automatic logic [31:0] vec_of(input logic [1:0] id);
    case (id)
      2'd0:    vec_of = VEC0;
      2'd1:    vec_of = VEC1;
      2'd2:    vec_of = VEC2;
      default: vec_of = 32'h0;
    endcase
  endfunction

  assign rise  = bus.int_src & ~src_q;
  assign avail = ir_q & ~irs_q;

  always_comb begin
    top_vld = |irs_q;
    top     = irs_q[2] ? 2'd2 : (irs_q[1] ? 2'd1 : 2'd0);
  end

  always_comb begin
    cand_vld = |avail;
    cand     = avail[2] ? 2'd2 : (avail[1] ? 2'd1 : 2'd0);
  end

  // Strict preemption: a candidate must outrank every in-service level.
  assign eligible = cand_vld && (!top_vld || (cand > top));

  // eret wins over a same-cycle ack; the request simply stays up.
  assign eret_ok  = bus.eret && (sp != 2'd0);
  assign accept   = (state == REQ) && bus.int_ack && !bus.eret;
  assign ack_mask = accept ? (3'b001 << req_id) : 3'b000;

  always_comb begin
    irs_nxt = irs_q;
    if (eret_ok) irs_nxt[top] = 1'b0;
    if (accept)  irs_nxt[req_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= 3'b000;
      ir_q      <= 3'b000;
      irs_q     <= 3'b000;
      sp        <= 2'd0;
      epc[0]    <= 32'h0;
      epc[1]    <= 32'h0;
      epc[2]    <= 32'h0;
      req_id    <= 2'd0;
      state     <= IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= 32'h0;
    end else begin
      src_q <= bus.int_src;
      // A fresh edge in the ack cycle re-arms the bit (set wins).
      ir_q  <= (ir_q & ~ack_mask) | rise;
      irs_q <= irs_nxt;

      if (accept) begin
        if (sp != 2'd3) epc[sp] <= bus.pc_in;
        sp <= sp + 2'd1;
      end else if (eret_ok) begin
        sp <= sp - 2'd1;
      end

      case (state)
        IDLE: begin
          if (eligible) begin
            state     <= REQ;
            req_id    <= cand;
            int_req_q <= 1'b1;
            int_vec_q <= vec_of(cand);
          end
        end
        REQ: begin
          if (accept) begin
            state     <= HOLD;
            int_req_q <= 1'b0;
            int_vec_q <= 32'h0;
          end
        end
        HOLD: state <= IDLE;  // one dead cycle for the pipeline flush
        default: begin
          state     <= IDLE;
          int_req_q <= 1'b0;
          int_vec_q <= 32'h0;
        end
      endcase
    end
  end

  assign bus.int_req = int_req_q;
  assign bus.int_vec = int_vec_q;
  assign bus.ir      = ir_q;
  assign bus.irs     = irs_q;
  assign bus.epc_out = (sp == 2'd0) ? 32'h0 : epc[sp - 2'd1];

endmodule

// File: tb/tb_int_service_ctrl.sv
// Bench for int_service_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_int_service_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src;
  logic        ack;
  logic        er;
  logic [31:0] pc;

  int n_chk = 0;
  int n_err = 0;

  int_service_ctrl_if bus();
  assign bus.int_src = src;
  assign bus.int_ack = ack;
  assign bus.eret    = er;
  assign bus.pc_in   = pc;

  int_service_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model
  localparam int P_WAIT = 0, P_REQ = 1, P_COOL = 2;
  logic [31:0] vecs [0:2] = '{32'h100, 32'h200, 32'h300};
  bit [2:0]    m_prev, m_pend, m_serv;
  int          m_phase, m_rid;
  logic [31:0] m_epc [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int top, cand;
    bit er_ok, acc;
    bit [2:0] rise;
    if (rst) begin
      m_prev = 0; m_pend = 0; m_serv = 0; m_phase = P_WAIT; m_rid = 0;
      m_epc.delete();
      return;
    end
    top = -1; cand = -1;
    for (int i = 0; i < 3; i++) begin
      if (m_serv[i]) top = i;
      if (m_pend[i] && !m_serv[i]) cand = i;
    end
    er_ok = er && (m_epc.size() > 0);
    acc   = (m_phase == P_REQ) && ack && !er;
    rise  = src & ~m_prev;
    if (er_ok) begin
      if (top >= 0) m_serv[top] = 1'b0;
      void'(m_epc.pop_back());
    end
    if (acc) begin
      m_serv[m_rid] = 1'b1;
      m_pend[m_rid] = 1'b0;
      m_epc.push_back(pc);
    end
    m_pend = m_pend | rise;
    m_prev = src;
    case (m_phase)
      P_WAIT: if (cand >= 0 && cand > top) begin m_phase = P_REQ; m_rid = cand; end
      P_REQ:  if (acc) m_phase = P_COOL;
      default: m_phase = P_WAIT;
    endcase
  endtask

  task automatic tick();
    logic [31:0] e_vec, e_epc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e_vec = (m_phase == P_REQ) ? vecs[m_rid] : 32'h0;
    e_epc = (m_epc.size() > 0) ? m_epc[m_epc.size()-1] : 32'h0;
    chk("int_req", {31'b0, bus.int_req}, {31'b0, m_phase == P_REQ});
    chk("int_vec", bus.int_vec, e_vec);
    chk("epc_out", bus.epc_out, e_epc);
    chk("ir",      {29'b0, bus.ir},  {29'b0, m_pend});
    chk("irs",     {29'b0, bus.irs}, {29'b0, m_serv});
  endtask

  task automatic idle_in();
    ack = 0; er = 0;
  endtask

  initial begin
    rst = 1; src = 0; ack = 0; er = 0; pc = 0;
    tick(); tick();
    chk("rst_req", {31'b0, bus.int_req}, 32'h0);
    chk("rst_epc", bus.epc_out, 32'h0);
    rst = 0;

    // Single source
    src = 3'b001; tick();
    chk("s1_ir", {29'b0, bus.ir}, 32'h1);
    chk("s1_req_lat", {31'b0, bus.int_req}, 32'h0);
    tick();
    chk("s1_req", {31'b0, bus.int_req}, 32'h1);
    chk("s1_vec", bus.int_vec, 32'h100);
    ack = 1; pc = 32'h40; tick(); idle_in();
    chk("s1_irs", {29'b0, bus.irs}, 32'h1);
    chk("s1_epc", bus.epc_out, 32'h40);
    tick();
    chk("s1_low2", {31'b0, bus.int_req}, 32'h0);

    // Nesting on top of source 0
    src = 3'b101; tick(); tick();
    chk("n_vec", bus.int_vec, 32'h300);
    ack = 1; pc = 32'h1008; tick(); idle_in();
    chk("n_irs", {29'b0, bus.irs}, 32'h5);
    chk("n_epc", bus.epc_out, 32'h1008);
    er = 1; tick(); idle_in();
    chk("n_ret_irs", {29'b0, bus.irs}, 32'h1);
    chk("n_ret_epc", bus.epc_out, 32'h40);
    er = 1; tick(); idle_in();
    chk("s1_ret_irs", {29'b0, bus.irs}, 32'h0);
    chk("s1_ret_epc", bus.epc_out, 32'h0);
    // eret with empty stack
    er = 1; tick(); idle_in();
    chk("empty_ret", {29'b0, bus.irs}, 32'h0);
    src = 3'b000; tick();

    // No lower-priority preemption
    src = 3'b100; tick(); tick();
    ack = 1; pc = 32'h2000; tick(); idle_in();
    tick();
    src = 3'b110; tick(); tick(); tick();
    chk("np_ir", {29'b0, bus.ir}, 32'h2);
    chk("np_noreq", {31'b0, bus.int_req}, 32'h0);
    er = 1; tick(); idle_in(); tick();
    chk("np_req", {31'b0, bus.int_req}, 32'h1);
    chk("np_vec", bus.int_vec, 32'h200);
    ack = 1; pc = 32'h2100; tick(); idle_in();
    er = 1; tick(); idle_in();

    // Simultaneous edges
    rst = 1; src = 0; tick(); rst = 0;
    src = 3'b111; tick(); tick();
    chk("sim_vec", bus.int_vec, 32'h300);
    ack = 1; pc = 32'h3000; tick(); idle_in();
    chk("sim_ir", {29'b0, bus.ir}, 32'h3);

    // Re-edge on source 0 in its ack cycle
    rst = 1; src = 0; tick(); rst = 0;
    src = 3'b001; tick(); tick();
    src = 3'b000; tick();
    src = 3'b001; ack = 1; pc = 32'h44; tick(); idle_in();
    chk("reedge_ir", {29'b0, bus.ir}, 32'h1);
    chk("reedge_irs", {29'b0, bus.irs}, 32'h1);

    // eret together with ack: ack ignored
    src = 3'b101; tick(); tick(); tick();
    chk("ea_pre", {31'b0, bus.int_req}, 32'h1);
    ack = 1; er = 1; pc = 32'h55; tick(); idle_in();
    chk("ea_req", {31'b0, bus.int_req}, 32'h1);
    chk("ea_irs", {29'b0, bus.irs}, 32'h0);
    ack = 1; pc = 32'h66; tick(); idle_in();
    chk("ea_acc", {29'b0, bus.irs}, 32'h4);

    // Reset with irs=011 and a request up
    rst = 1; src = 0; tick(); rst = 0;
    src = 3'b001; tick(); tick(); ack = 1; pc = 32'h10; tick(); idle_in(); tick();
    src = 3'b011; tick(); tick(); ack = 1; pc = 32'h20; tick(); idle_in(); tick();
    src = 3'b111; tick(); tick();
    chk("mid_irs", {29'b0, bus.irs}, 32'h3);
    chk("mid_req", {31'b0, bus.int_req}, 32'h1);
    rst = 1; tick(); rst = 0; src = 0;
    chk("mid_rst_req", {31'b0, bus.int_req}, 32'h0);
    chk("mid_rst_irs", {29'b0, bus.irs}, 32'h0);
    chk("mid_rst_epc", bus.epc_out, 32'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ 3'($urandom_range(0, 7));
      ack = (m_phase == P_REQ) && ($urandom_range(0, 2) == 0);
      er  = ($urandom_range(0, 9) == 0);
      pc  = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; idle_in();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/int_service_ctrl.md
# int_service_ctrl

Interrupt service controller: the service-tracking counterpart of the priority selector. It latches rising edges on three interrupt sources into a pending register IR and tracks in-service interrupts in IRS. It requests the pipeline with a handler vector and saves the interrupted PC on a 3-deep EPC stack at acknowledge. On `eret` it retires the innermost in-service level. It sits between the interrupt sources and the pipeline's PC/flush logic.

## Interface
- `VEC0`, default 32'h0000_0100, handler address for source 0 (lowest priority)
- `VEC1`, default 32'h0000_0200, handler address for source 1
- `VEC2`, default 32'h0000_0300, handler address for source 2 (highest priority)
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `int_src`  in  3  raw interrupt source levels; a 0→1 transition is a request
- `int_ack`  in  1  pipeline accepts the pending request this cycle
- `eret`  in  1  return-from-interrupt retiring this cycle
- `pc_in`  in  32  PC to resume at, sampled on accepted `int_ack`
- `int_req`  out  1  interrupt request to pipeline
- `int_vec`  out  32  handler address for the requested source; 0 when `int_req`=0
- `epc_out`  out  32  top of EPC stack (resume PC for `eret`); 0 when stack empty
- `ir`  out  3  pending register
- `irs`  out  3  in-service register

## Operation
- Edge detect: `src_q` <= `int_src`; `rise` = `int_src & ~src_q`. `src_q` resets to 0, so a source held high through reset produces an edge in the first cycle after reset.
- `ir[i]` set on `rise[i]`; cleared when source i is accepted. Set and clear in the same cycle: set wins, so the new request is kept pending.
- `top` = index of highest set IRS bit; none if IRS=0.
- Candidate = highest-priority i with `ir[i]`=1 and `irs[i]`=0. It is eligible only if IRS=0 or i > `top`, i.e. strict preemption.
- FSM states IDLE, REQ, HOLD:
  - IDLE: if an eligible candidate exists, latch `req_id` and go to REQ.
  - REQ: `int_req`=1 and `int_vec`=VEC[`req_id`]; `req_id` is frozen. On `int_ack` with `eret`=0:
    - push `pc_in`, sp++
    - set `irs[req_id]`, clear `ir[req_id]`
    - go to HOLD
  - HOLD: `int_req`=0 for one cycle while the pipeline flush completes, then go to IDLE.
- `eret` (any state) with sp>0: clear `irs[top]`, sp--. `epc_out` shows the new top from the next cycle. `eret` with sp=0 is ignored.
- `eret` and `int_ack` in the same cycle: `eret` is processed and `int_ack` is ignored. The FSM stays in REQ with the same `req_id`, which remains eligible.
- EPC stack: 3 × 32, sp 0..3. Strict preemption bounds depth to 3. An `int_ack` with sp=3 cannot occur and needs no handling.

## Timing
- Reset values: `int_req`=0, `int_vec`=0, `epc_out`=0, `ir`=0, `irs`=0, sp=0, FSM=IDLE, `src_q`=0. `rst` overrides all other inputs in the same cycle.
- Latency: with `rise` sampled at edge N, `ir` is set after N and `int_req` is high after N+1.
- `int_req` holds high until an accepted `int_ack`. After acceptance there are at least 2 cycles low: HOLD, then IDLE re-evaluation.
- `irs`, `ir`, and `epc_out` update one cycle after `int_ack`/`eret`.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Single source: rising edge on `int_src[0]` → `int_req`=1 two cycles later with `int_vec`=0x100. Ack with `pc_in`=0x40 → `irs`=3'b001, `ir`=0, `epc_out`=0x40. `eret` → `irs`=0, `epc_out`=0.
- Nesting: source 0 in service with EPC 0x40. Edge on source 2 → request with `int_vec`=0x300. Ack with `pc_in`=0x1008 → `irs`=3'b101, `epc_out`=0x1008. `eret` → `irs`=3'b001, `epc_out`=0x40.
- No lower-priority preemption: source 2 in service. Edge on source 1 → `ir`=3'b010 and `int_req` stays 0. After `eret` → `int_req`=1 with `int_vec`=0x200.
- Simultaneous edges on all three sources → source 2 is served first. `ir` holds 3'b011 after the ack.
- Collisions:
  - Re-edge on source 0 in the same cycle as its `int_ack` → `ir[0]` stays 1.
  - `eret` together with `int_ack` → ack ignored, `int_req` stays 1.
  - `eret` with an empty stack → no change.
- Reset mid-operation with `irs`=3'b011 and FSM in REQ → all outputs 0 on the next cycle and FSM in IDLE.
